// File: rtl/leaf_bridge_pkg.sv
// Shared types and constants for leaf_port_bridge: sequencer states and statistics counter sizing.
package leaf_bridge_pkg;

  localparam int unsigned STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    ST_RESET,
    ST_WAIT,
    ST_RUN,
    ST_FLUSH
  } state_t;

  localparam int unsigned STAT_BITS = 32;
  localparam logic [STAT_BITS-1:0] STAT_SAT = '1;

endpackage

// File: rtl/leaf_bridge_fifo.sv
// Single-clock 1R1W FIFO with vld/ack handshakes on both sides, async reset and sync flush.
// Handshakes are masked while en is low; output data reads as zero whenever nothing is valid.
module leaf_bridge_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_ack
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push;
  logic                  pop;

  // Validity comes from the registered count only, so a fresh word is never bypassed to the output.
  assign in_ack   = en && (count != FULL_COUNT);
  assign out_vld  = en && (count != '0);
  assign out_data = out_vld ? mem[rd_ptr] : '0;
  assign push     = in_vld && in_ack;
  assign pop      = out_vld && out_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/leaf_port_bridge.sv
// Buffers leaf_interface ports to/from an ap_vld/ap_ack HLS kernel, sequences kernel start/reset
// and flushes on BFT resend. Define LEAF_BRIDGE_STATS_EN to build per-port transfer counters.
module leaf_port_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS    = 32,
  parameter int unsigned NUM_IN_PORTS    = 1,
  parameter int unsigned NUM_OUT_PORTS   = 1,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  parameter int unsigned START_DELAY     = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          ap_start,
  input  logic                                          resend,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]          if_din,
  input  logic [NUM_IN_PORTS-1:0]                       if_vld,
  output logic [NUM_IN_PORTS-1:0]                       if_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]          k_dout,
  output logic [NUM_IN_PORTS-1:0]                       k_vld,
  input  logic [NUM_IN_PORTS-1:0]                       k_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]         k_din,
  input  logic [NUM_OUT_PORTS-1:0]                      k_din_vld,
  output logic [NUM_OUT_PORTS-1:0]                      k_din_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]         if_dout,
  output logic [NUM_OUT_PORTS-1:0]                      if_dout_vld,
  input  logic [NUM_OUT_PORTS-1:0]                      if_dout_ack,
  output logic                                          k_ap_start,
  output logic                                          k_ap_rst,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*STAT_BITS-1:0] stat_count
);

  localparam int unsigned NUM_PORTS = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int unsigned DLY_BITS  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_BITS-1:0] DLY_LAST = DLY_BITS'(START_DELAY - 1);

  state_t              state_q, state_d;
  logic [DLY_BITS-1:0] dly_q, dly_d;
  logic                first_q;
  logic                fifo_en;
  logic                fifo_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      dly_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      first_q <= (state_d == ST_WAIT) && (state_q != ST_WAIT);
    end
  end

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    fifo_en    = 1'b0;
    fifo_flush = 1'b0;
    k_ap_start = 1'b0;
    k_ap_rst   = 1'b0;
    case (state_q)
      ST_RESET: begin
        k_ap_rst = 1'b1;
        state_d  = ST_WAIT;
        dly_d    = '0;
      end
      ST_WAIT: begin
        fifo_en  = 1'b1;
        k_ap_rst = first_q;
        if (resend) begin
          state_d = ST_FLUSH;
          dly_d   = '0;
        end else if (!ap_start) begin
          dly_d = '0;
        end else if (dly_q == DLY_LAST) begin
          state_d = ST_RUN;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_RUN: begin
        fifo_en    = 1'b1;
        k_ap_start = 1'b1;
        if (resend) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        k_ap_rst   = 1'b1;
        fifo_flush = 1'b1;
        state_d    = ST_WAIT;
        dly_d      = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    leaf_bridge_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk      (clk),
      .rst      (reset),
      .en       (fifo_en),
      .flush    (fifo_flush),
      .in_data  (if_din[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .in_vld   (if_vld[i]),
      .in_ack   (if_ack[i]),
      .out_data (k_dout[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .out_vld  (k_vld[i]),
      .out_ack  (k_ack[i])
    );
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    leaf_bridge_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk      (clk),
      .rst      (reset),
      .en       (fifo_en),
      .flush    (fifo_flush),
      .in_data  (k_din[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .in_vld   (k_din_vld[j]),
      .in_ack   (k_din_ack[j]),
      .out_data (if_dout[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .out_vld  (if_dout_vld[j]),
      .out_ack  (if_dout_ack[j])
    );
  end

`ifdef LEAF_BRIDGE_STATS_EN
  // Counters see kernel-side transfers only and survive a flush; inputs first, then outputs.
  logic [NUM_PORTS-1:0] k_xfer;
  assign k_xfer = {k_din_vld & k_din_ack, k_vld & k_ack};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stat
    logic [STAT_BITS-1:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else if (k_xfer[p] && (cnt_q != STAT_SAT)) cnt_q <= cnt_q + 1'b1;
    end
    assign stat_count[p*STAT_BITS +: STAT_BITS] = cnt_q;
  end
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_leaf_port_bridge.sv
// Scoreboard bench for leaf_port_bridge (3 in, 2 out ports): a negedge monitor compares every
// output against queue-based port models and a phase model of the start/flush sequencing.
module tb_leaf_port_bridge;

  localparam int unsigned W     = 32;
  localparam int unsigned NI    = 3;
  localparam int unsigned NO    = 2;
  localparam int unsigned DL2   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SD    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ap_start = 1'b0;
  logic              resend = 1'b0;
  logic [NI*W-1:0]   if_din = '0;
  logic [NI-1:0]     if_vld = '0;
  logic [NI-1:0]     if_ack;
  logic [NI*W-1:0]   k_dout;
  logic [NI-1:0]     k_vld;
  logic [NI-1:0]     k_ack = '0;
  logic [NO*W-1:0]   k_din = '0;
  logic [NO-1:0]     k_din_vld = '0;
  logic [NO-1:0]     k_din_ack;
  logic [NO*W-1:0]   if_dout;
  logic [NO-1:0]     if_dout_vld;
  logic [NO-1:0]     if_dout_ack = '0;
  logic              k_ap_start;
  logic              k_ap_rst;
  logic [(NI+NO)*32-1:0] stat_count;

  int n_checks = 0;
  int n_fail   = 0;

  leaf_port_bridge #(
    .PAYLOAD_BITS    (W),
    .NUM_IN_PORTS    (NI),
    .NUM_OUT_PORTS   (NO),
    .FIFO_DEPTH_LOG2 (DL2),
    .START_DELAY     (SD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ap_start    (ap_start),
    .resend      (resend),
    .if_din      (if_din),
    .if_vld      (if_vld),
    .if_ack      (if_ack),
    .k_dout      (k_dout),
    .k_vld       (k_vld),
    .k_ack       (k_ack),
    .k_din       (k_din),
    .k_din_vld   (k_din_vld),
    .k_din_ack   (k_din_ack),
    .if_dout     (if_dout),
    .if_dout_vld (if_dout_vld),
    .if_dout_ack (if_dout_ack),
    .k_ap_start  (k_ap_start),
    .k_ap_rst    (k_ap_rst),
    .stat_count  (stat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-port word queues plus the bridge phase.
  typedef enum {M_RST, M_WAIT, M_RUN, M_FLUSH} mphase_t;
  mphase_t     m_phase = M_RST;
  int          m_wait_run = 0;
  bit          m_first = 1'b0;
  logic [31:0] q_in  [NI][$];
  logic [31:0] q_out [NO][$];
  bit          m_en, e_ack, e_vld;
  logic [31:0] e_dat;

  task automatic clear_model();
    for (int i = 0; i < NI; i++) q_in[i].delete();
    for (int j = 0; j < NO; j++) q_out[j].delete();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_phase = M_RST;
        m_wait_run = 0;
        m_first = 1'b0;
        clear_model();
        chk("rst_k_ap_rst", k_ap_rst, 1);
        chk("rst_k_ap_start", k_ap_start, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_k_vld", k_vld, 0);
        chk("rst_k_din_ack", k_din_ack, 0);
        chk("rst_if_dout_vld", if_dout_vld, 0);
        chk("rst_k_dout_nonzero", k_dout != '0, 0);
        chk("rst_if_dout_nonzero", if_dout != '0, 0);
        chk("rst_stat_nonzero", stat_count != '0, 0);
      end else begin
        m_en = (m_phase == M_WAIT) || (m_phase == M_RUN);
        chk("k_ap_start", k_ap_start, m_phase == M_RUN);
        chk("k_ap_rst", k_ap_rst,
            (m_phase == M_RST) || (m_phase == M_FLUSH) || ((m_phase == M_WAIT) && m_first));
        for (int i = 0; i < NI; i++) begin
          e_ack = m_en && (q_in[i].size() < DEPTH);
          e_vld = m_en && (q_in[i].size() > 0);
          e_dat = e_vld ? q_in[i][0] : 32'h0;
          chk($sformatf("if_ack[%0d]", i), if_ack[i], e_ack);
          chk($sformatf("k_vld[%0d]", i), k_vld[i], e_vld);
          chk($sformatf("k_dout[%0d]", i), k_dout[i*W +: W], e_dat);
          if (if_vld[i] && e_ack) q_in[i].push_back(if_din[i*W +: W]);
          if (e_vld && k_ack[i]) void'(q_in[i].pop_front());
        end
        for (int j = 0; j < NO; j++) begin
          e_ack = m_en && (q_out[j].size() < DEPTH);
          e_vld = m_en && (q_out[j].size() > 0);
          e_dat = e_vld ? q_out[j][0] : 32'h0;
          chk($sformatf("k_din_ack[%0d]", j), k_din_ack[j], e_ack);
          chk($sformatf("if_dout_vld[%0d]", j), if_dout_vld[j], e_vld);
          chk($sformatf("if_dout[%0d]", j), if_dout[j*W +: W], e_dat);
          if (k_din_vld[j] && e_ack) q_out[j].push_back(k_din[j*W +: W]);
          if (e_vld && if_dout_ack[j]) void'(q_out[j].pop_front());
        end
`ifndef LEAF_BRIDGE_STATS_EN
        chk("stat_nonzero", stat_count != '0, 0);
`endif
        // Phase advance: start needs SD consecutive WAIT cycles with ap_start high.
        case (m_phase)
          M_RST: begin
            m_phase = M_WAIT; m_wait_run = 0; m_first = 1'b1;
          end
          M_WAIT: begin
            m_first = 1'b0;
            if (resend) m_phase = M_FLUSH;
            else if (!ap_start) m_wait_run = 0;
            else begin
              m_wait_run++;
              if (m_wait_run == SD) m_phase = M_RUN;
            end
          end
          M_RUN: if (resend) m_phase = M_FLUSH;
          M_FLUSH: begin
            clear_model();
            m_phase = M_WAIT; m_wait_run = 0; m_first = 1'b1;
          end
        endcase
      end
    end
  end

  task automatic send_in(input int p, input logic [31:0] d);
    bit done = 1'b0;
    if_din[p*W +: W] = d;
    if_vld[p] = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      done = if_ack[p];
      @(posedge clk); #1;
    end
    if_vld[p] = 1'b0;
    chk("send_in_accepted", done, 1);
  endtask

  task automatic send_out(input int p, input logic [31:0] d);
    bit done = 1'b0;
    k_din[p*W +: W] = d;
    k_din_vld[p] = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      done = k_din_ack[p];
      @(posedge clk); #1;
    end
    k_din_vld[p] = 1'b0;
    chk("send_out_accepted", done, 1);
  endtask

  task automatic step(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    int seq;
    logic [31:0] words [4];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    seq = 0;

    // Reset release and start sequencing
    ap_start = 1'b1;
    step(3);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("wait1_k_ap_rst", k_ap_rst, 1);
    @(posedge clk); #1;
    chk("wait2_k_ap_rst", k_ap_rst, 0);
    n = 2;
    while (!k_ap_start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("start_latency", n, SD + 1);

    // Fill input port 0 with kernel stalled, then drain
    for (int i = 0; i < 4; i++) send_in(0, words[i]);
    @(negedge clk);
    chk("full_if_ack0", if_ack[0], 0);
    chk("full_k_vld0", k_vld[0], 1);
    step(2);
    k_ack[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_vld", k_vld[0], 1);
      chk("drain_data", k_dout[31:0], words[i]);
    end
    step(2);

    // Streaming 0..99 with kernel always ready
    for (int v = 0; v < 100; v++) send_in(0, 32'(v));
    step(3);
    k_ack[0] = 1'b0;

    // Buffered output words discarded by resend
    if_dout_ack = '0;
    for (int i = 0; i < 3; i++) send_out(0, 32'hA0 + 32'(i));
    resend = 1'b1;
    @(posedge clk); #1;
    resend = 1'b0;
    chk("flush_k_ap_rst", k_ap_rst, 1);
    chk("flush_if_dout_vld", if_dout_vld, 0);
    n = 1;
    while (!k_ap_start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("restart_latency", n, SD + 2);
    if_dout_ack = '1;
    step(4);
    if_dout_ack = '0;

    // Random multi-port traffic with resends, ap_start dips and a mid-run reset
    for (int c = 0; c < 1500; c++) begin
      reset       = (c >= 700) && (c < 703);
      ap_start    = ($urandom_range(0, 19) != 0);
      resend      = ($urandom_range(0, 149) == 0);
      if_vld      = NI'($urandom);
      k_ack       = NI'($urandom);
      k_din_vld   = NO'($urandom);
      if_dout_ack = NO'($urandom);
      for (int p = 0; p < NI; p++) begin
        if_din[p*W +: W] = {8'(p), 24'(seq)};
        seq++;
      end
      for (int p = 0; p < NO; p++) begin
        k_din[p*W +: W] = {8'(p + 16), 24'(seq)};
        seq++;
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; resend = 1'b0; ap_start = 1'b1;
    if_vld = '0; k_ack = '0; k_din_vld = '0; if_dout_ack = '0;
    step(SD + 4);

`ifdef LEAF_BRIDGE_STATS_EN
    // Saturation of the input-port-0 transfer counter
    force dut.g_stat[0].cnt_q = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    release dut.g_stat[0].cnt_q;
    k_ack[0] = 1'b1;
    for (int i = 0; i < 5; i++) send_in(0, 32'hC0 + 32'(i));
    step(3);
    k_ack[0] = 1'b0;
    chk("stat_saturated", stat_count[31:0], 32'hFFFF_FFFF);
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
